memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_if.sv | 16 +
 rtl/memory_responder.sv | 83 ++++++++
 tb/tb_memory_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
// Processor-side memory bus: request strobes/address/data in, load data and
// completion/error pulses out.
interface memory_responder_if;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Fault;

  modport master (output Adr, WriteData, MemRead, MemWrite,
                  input  ReadData, Ready, Fault);
  modport slave  (input  Adr, WriteData, MemRead, MemWrite,
                  output ReadData, Ready, Fault);
endinterface

// File: rtl/memory_responder.sv
// Fixed-latency word memory: captures one request in IDLE, waits WAIT_CYCLES,
// then completes it with a one-cycle Ready (and Fault on bad requests).
module memory_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 6
) (
  input  logic               Clk,
  input  logic               Rst,
  memory_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           data;
    logic                  wr;
    logic                  fault;
  } req_t;

  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  req_t        req_q, req_in, eff;
  logic        start, enter_resp;
  logic [31:0] rdata;
  logic [31:0] mem [WORDS];

  always_comb begin
    start        = bus.MemRead | bus.MemWrite;
    req_in.idx   = bus.Adr[DEPTH_LOG2+1:2];
    req_in.data  = bus.WriteData;
    req_in.wr    = bus.MemWrite;
    req_in.fault = (bus.MemRead & bus.MemWrite) | (bus.Adr[1:0] != 2'b00) |
                   ((bus.Adr >> (DEPTH_LOG2 + 2)) != 32'd0);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (start) begin
        cnt_nxt   = CNT_INIT;
        state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait cycles the array access happens on the capture edge itself,
  // so the live request is used instead of the captured copy.
  assign eff        = (state == IDLE) ? req_in : req_q;
  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      req_q <= '0;
      rdata <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && start) req_q <= req_in;
      if (enter_resp) begin
        if (eff.fault)    rdata <= 32'd0;
        else if (!eff.wr) rdata <= mem[eff.idx];
      end
    end
  end

  // Array is deliberately not reset; Rst gating keeps an aborted write out.
  always_ff @(posedge Clk) begin
    if (Rst && enter_resp && eff.wr && !eff.fault) mem[eff.idx] <= eff.data;
  end

  assign bus.ReadData = rdata;
  assign bus.Ready    = (state == RESP);
  assign bus.Fault    = (state == RESP) && req_q.fault;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: one responder with WAIT_CYCLES=2 and one with WAIT_CYCLES=0.
module tb_memory_responder;
  logic Clk = 1'b0;
  logic Rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  memory_responder_if ba ();
  memory_responder_if bz ();

  memory_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(6)) dut_a (.Clk(Clk), .Rst(Rst), .bus(ba));
  memory_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(6)) dut_z (.Clk(Clk), .Rst(Rst), .bus(bz));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge Clk);
    #1;
  endtask

  // WAIT_CYCLES=2: capture at edge 0, Ready only in the cycle after edge 2.
  task automatic req_a(input logic rd, input logic wr, input logic [31:0] adr,
                       input logic [31:0] data, input logic f_exp,
                       input logic [31:0] rd_exp, input string tag);
    @(negedge Clk);
    ba.MemRead = rd; ba.MemWrite = wr; ba.Adr = adr; ba.WriteData = data;
    edge_sample();
    chk({tag, ".rdy_e0"}, 32'(ba.Ready), 32'd0);
    ba.MemRead = 1'b0; ba.MemWrite = 1'b0;
    edge_sample();
    chk({tag, ".rdy_e1"}, 32'(ba.Ready), 32'd0);
    edge_sample();
    chk({tag, ".rdy_e2"}, 32'(ba.Ready), 32'd1);
    chk({tag, ".fault"},  32'(ba.Fault), 32'(f_exp));
    chk({tag, ".rdata"},  ba.ReadData, rd_exp);
    edge_sample();
    chk({tag, ".rdy_e3"}, 32'(ba.Ready), 32'd0);
  endtask

  // WAIT_CYCLES=0: Ready in the cycle right after the capture edge.
  task automatic req_z(input logic rd, input logic wr, input logic [31:0] adr,
                       input logic [31:0] data, input logic f_exp,
                       input logic [31:0] rd_exp, input string tag);
    @(negedge Clk);
    bz.MemRead = rd; bz.MemWrite = wr; bz.Adr = adr; bz.WriteData = data;
    edge_sample();
    chk({tag, ".rdy_e0"}, 32'(bz.Ready), 32'd1);
    chk({tag, ".fault"},  32'(bz.Fault), 32'(f_exp));
    chk({tag, ".rdata"},  bz.ReadData, rd_exp);
    bz.MemRead = 1'b0; bz.MemWrite = 1'b0;
    edge_sample();
    chk({tag, ".rdy_e1"}, 32'(bz.Ready), 32'd0);
  endtask

  initial begin
    Rst = 1'b0;
    ba.MemRead = 1'b0; ba.MemWrite = 1'b0; ba.Adr = '0; ba.WriteData = '0;
    bz.MemRead = 1'b0; bz.MemWrite = 1'b0; bz.Adr = '0; bz.WriteData = '0;
    #2;
    chk("rst.a_ready", 32'(ba.Ready), 32'd0);
    chk("rst.a_fault", 32'(ba.Fault), 32'd0);
    chk("rst.a_rdata", ba.ReadData,   32'd0);
    chk("rst.z_ready", 32'(bz.Ready), 32'd0);
    chk("rst.z_rdata", bz.ReadData,   32'd0);
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b1;

    // Basic write then read back
    req_a(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        "wr10");
    req_a(1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, "rd10");
    // Misaligned and out-of-range reads fault and zero ReadData
    req_a(1'b1, 1'b0, 32'h13,  32'h0, 1'b1, 32'h0, "rd13_mis");
    req_a(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, "rd400_oor");
    req_a(1'b1, 1'b0, 32'h10,  32'h0, 1'b0, 32'hDEADBEEF, "rd10_again");
    // Both strobes: fault, no write
    req_a(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'hDEADBEEF, "wr20");
    req_a(1'b1, 1'b1, 32'h20, 32'h00000001, 1'b1, 32'h0,        "both20");
    req_a(1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h12345678, "rd20");

    // Held MemRead: a Ready every 4 edges, junk on the bus while busy is ignored
    req_a(1'b0, 1'b1, 32'h14, 32'hA5A5A5A5, 1'b0, 32'h12345678, "wr14");
    @(negedge Clk);
    ba.MemRead = 1'b1; ba.Adr = 32'h14;
    for (int k = 0; k < 12; k++) begin
      edge_sample();
      chk($sformatf("hold.rdy_k%0d", k), 32'(ba.Ready), (k % 4 == 2) ? 32'd1 : 32'd0);
      if (k % 4 == 2) begin
        chk($sformatf("hold.rdata_k%0d", k), ba.ReadData, 32'hA5A5A5A5);
        chk($sformatf("hold.fault_k%0d", k), 32'(ba.Fault), 32'd0);
      end
      if (k % 4 == 3) begin
        ba.MemWrite = 1'b0; ba.Adr = 32'h14; ba.WriteData = 32'h0;
      end else begin
        ba.MemWrite = 1'b1; ba.Adr = 32'h3; ba.WriteData = 32'hFFFFFFFF;
      end
    end
    ba.MemRead = 1'b0; ba.MemWrite = 1'b0;

    // Reset during WAIT aborts a pending write
    req_a(1'b0, 1'b1, 32'h30, 32'h11111111, 1'b0, 32'hA5A5A5A5, "wr30");
    @(negedge Clk);
    ba.MemWrite = 1'b1; ba.Adr = 32'h30; ba.WriteData = 32'h22222222;
    edge_sample();
    ba.MemWrite = 1'b0;
    edge_sample();
    Rst = 1'b0;
    #1;
    chk("abort.ready", 32'(ba.Ready), 32'd0);
    chk("abort.fault", 32'(ba.Fault), 32'd0);
    chk("abort.rdata", ba.ReadData,   32'd0);
    @(negedge Clk);
    edge_sample();
    chk("abort.ready_in_rst", 32'(ba.Ready), 32'd0);
    Rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_sample();
      chk($sformatf("abort.ready_after_k%0d", k), 32'(ba.Ready), 32'd0);
    end
    req_a(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h11111111, "rd30");

    // Zero wait cycles
    req_z(1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0, 32'h0,        "z_wr8");
    req_z(1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 32'hCAFEF00D, "z_rd8");
    req_z(1'b1, 1'b0, 32'h2, 32'h0,        1'b1, 32'h0,        "z_rd2_mis");
    @(negedge Clk);
    bz.MemRead = 1'b1; bz.Adr = 32'h8;
    for (int k = 0; k < 6; k++) begin
      edge_sample();
      chk($sformatf("z_hold.rdy_k%0d", k), 32'(bz.Ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk($sformatf("z_hold.rdata_k%0d", k), bz.ReadData, 32'hCAFEF00D);
    end
    bz.MemRead = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
